// File: rtl/sitcp_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the SiTCP TCP TX byte stream.
// Optional macro TX_SRC_TAG_EN inserts a one-byte source tag before each packet.
module sitcp_tx_arbiter #(
    parameter int NSRC  = 4,
    parameter int CNT_W = 16
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                SiTCP_RST,
    input  logic                OPEN_ACK,
    input  logic                TX_FULL,
    output logic                TX_WR,
    output logic [7:0]          TX_DATA,
    input  logic [NSRC-1:0]     SRC_VALID,
    input  logic [8*NSRC-1:0]   SRC_DATA,
    input  logic [NSRC-1:0]     SRC_LAST,
    output logic [NSRC-1:0]     SRC_READY,
    output logic [NSRC-1:0]     GRANT,
    output logic                ACTIVE,
    output logic [CNT_W-1:0]    DROP_CNT,
    output logic [2:0]          DBG_STATE
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_TAG   = 3'd2,
        S_XFER  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     gidx_q;
    logic [NSRC-1:0]   grant_q;
    logic              tx_wr_q;
    logic [7:0]        tx_data_q;
    logic [CNT_W-1:0]  drop_q;

    // Rotating scan from ptr_q; walking k downwards lets the nearest valid source win.
    logic [PW:0]       arb_idx;
    logic [PW-1:0]     arb_sel;
    logic              arb_found;

    always_comb begin
        arb_idx   = '0;
        arb_sel   = '0;
        arb_found = 1'b0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            arb_idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (arb_idx >= (PW+1)'(NSRC)) begin
                arb_idx = arb_idx - (PW+1)'(NSRC);
            end
            if (SRC_VALID[arb_idx[PW-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx[PW-1:0];
            end
        end
    end

    logic          sel_valid;
    logic          sel_last;
    logic [7:0]    sel_data;
    logic          xfer_rdy;
    logic          xfer_hs;
    logic          rdy_bit;
    logic [PW-1:0] next_ptr;

    assign sel_valid = SRC_VALID[gidx_q];
    assign sel_last  = SRC_LAST[gidx_q];
    assign sel_data  = SRC_DATA[{gidx_q, 3'b000} +: 8];
    assign xfer_rdy  = OPEN_ACK & ~TX_FULL;
    assign xfer_hs   = sel_valid & xfer_rdy;
    assign next_ptr  = (gidx_q == PW'(NSRC - 1)) ? '0 : gidx_q + 1'b1;

    // Valid/ready: a byte moves on a clock edge where both SRC_VALID[g] and SRC_READY[g] are high;
    // ready is combinational so TX_FULL and a closing connection stall the source in the same cycle.
    always_comb begin
        rdy_bit = 1'b0;
        if (state_q == S_XFER) begin
            rdy_bit = xfer_rdy;
        end else if (state_q == S_FLUSH) begin
            rdy_bit = 1'b1;
        end
        SRC_READY = grant_q & {NSRC{rdy_bit}};
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
            drop_q    <= '0;
        end else if (SiTCP_RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
            drop_q    <= '0;
        end else begin
            tx_wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (OPEN_ACK && (|SRC_VALID)) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (OPEN_ACK && arb_found) begin
                        grant_q <= NSRC'(1) << arb_sel;
                        gidx_q  <= arb_sel;
`ifdef TX_SRC_TAG_EN
                        state_q <= S_TAG;
`else
                        state_q <= S_XFER;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
`ifdef TX_SRC_TAG_EN
                S_TAG: begin
                    // A close before the tag goes out abandons the grant without touching data.
                    if (!OPEN_ACK) begin
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else if (!TX_FULL) begin
                        tx_wr_q   <= 1'b1;
                        tx_data_q <= {4'hA, 1'b0, 3'(gidx_q)};
                        state_q   <= S_XFER;
                    end
                end
`endif
                S_XFER: begin
                    if (xfer_hs) begin
                        tx_wr_q   <= 1'b1;
                        tx_data_q <= sel_data;
                    end
                    if (xfer_hs && sel_last) begin
                        ptr_q   <= next_ptr;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else if (!OPEN_ACK) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (sel_valid && sel_last) begin
                        if (drop_q != '1) begin
                            drop_q <= drop_q + 1'b1;
                        end
                        ptr_q   <= next_ptr;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign TX_WR     = tx_wr_q;
    assign TX_DATA   = tx_data_q;
    assign GRANT     = grant_q;
    assign ACTIVE    = (state_q == S_XFER) || (state_q == S_TAG) || (state_q == S_FLUSH);
    assign DROP_CNT  = drop_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_sitcp_tx_arbiter.sv
// Scoreboard bench for sitcp_tx_arbiter: queued source packets, expected TX bytes and grant order.
module tb_sitcp_tx_arbiter;
    localparam int NSRC  = 4;
    localparam int CNT_W = 16;

    logic              CLK;
    logic              RSTn;
    logic              SiTCP_RST;
    logic              OPEN_ACK;
    logic              TX_FULL;
    logic              TX_WR;
    logic [7:0]        TX_DATA;
    logic [NSRC-1:0]   SRC_VALID;
    logic [8*NSRC-1:0] SRC_DATA;
    logic [NSRC-1:0]   SRC_LAST;
    logic [NSRC-1:0]   SRC_READY;
    logic [NSRC-1:0]   GRANT;
    logic              ACTIVE;
    logic [CNT_W-1:0]  DROP_CNT;
    logic [2:0]        DBG_STATE;

    sitcp_tx_arbiter #(.NSRC(NSRC), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RSTn(RSTn), .SiTCP_RST(SiTCP_RST), .OPEN_ACK(OPEN_ACK), .TX_FULL(TX_FULL),
        .TX_WR(TX_WR), .TX_DATA(TX_DATA), .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA),
        .SRC_LAST(SRC_LAST), .SRC_READY(SRC_READY), .GRANT(GRANT), .ACTIVE(ACTIVE),
        .DROP_CNT(DROP_CNT), .DBG_STATE(DBG_STATE)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [7:0]      exp_q[$];
    logic [8:0]      src_q[NSRC][$];
    logic [NSRC-1:0] grant_log[$];
    logic [NSRC-1:0] hs_seen;
    logic [NSRC-1:0] prev_grant;
    logic            exp_wr_next;
    logic            gap_en;
    logic            gap_seen;
    int              zero_run;
    int              acc_cnt[NSRC];
    int              n_checks;
    int              n_errors;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [NSRC-1:0] pop_grant();
        if (grant_log.size() == 0) return '0;
        return grant_log.pop_front();
    endfunction

    // source driver: pops bytes handshaken at the previous edge, presents the next one
    initial begin
        SRC_VALID = '0;
        SRC_DATA  = '0;
        SRC_LAST  = '0;
        for (int i = 0; i < NSRC; i++) acc_cnt[i] = 0;
        forever begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < NSRC; i++) begin
                if (hs_seen[i] && src_q[i].size() != 0) begin
                    void'(src_q[i].pop_front());
                    acc_cnt[i]++;
                end
                if (src_q[i].size() != 0) begin
                    SRC_VALID[i]       = 1'b1;
                    SRC_LAST[i]        = src_q[i][0][8];
                    SRC_DATA[8*i +: 8] = src_q[i][0][7:0];
                end else begin
                    SRC_VALID[i]       = 1'b0;
                    SRC_LAST[i]        = 1'b0;
                    SRC_DATA[8*i +: 8] = 8'h00;
                end
            end
        end
    end

    // monitor: sampled at the falling edge, away from the active edge
    initial begin
        hs_seen     = '0;
        prev_grant  = '0;
        exp_wr_next = 1'b0;
        zero_run    = 0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                hs_seen     = '0;
                exp_wr_next = 1'b0;
                prev_grant  = '0;
            end else begin
`ifdef TX_SRC_TAG_EN
                if (exp_wr_next) chk("tx_wr_lat", TX_WR, 1);
`else
                chk("tx_wr_lat", TX_WR, exp_wr_next);
`endif
                if (TX_WR) begin
                    if (exp_q.size() == 0) chk("tx_unexpected", TX_DATA, 32'hFFFF_FFFF);
                    else chk("tx_data", TX_DATA, exp_q.pop_front());
                end
                chk("rdy_not_granted", SRC_READY & ~GRANT, 0);
                if (TX_FULL && OPEN_ACK) chk("rdy_full", SRC_READY, 0);
                chk("grant_onehot", $onehot0(GRANT), 1);
                if (GRANT != 0 && prev_grant == 0) begin
                    grant_log.push_back(GRANT);
                    if (gap_en && gap_seen) chk("rr_gap", zero_run, 2);
                    gap_seen = 1'b1;
                    zero_run = 0;
                end else if (GRANT == 0) begin
                    zero_run++;
                end
                prev_grant = GRANT;
                if (SiTCP_RST) begin
                    hs_seen     = '0;
                    exp_wr_next = 1'b0;
                end else begin
                    hs_seen     = SRC_VALID & SRC_READY;
                    exp_wr_next = (|hs_seen) && OPEN_ACK && !TX_FULL;
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic push_pkt(input int s, input int n, input int base);
        for (int k = 0; k < n; k++) src_q[s].push_back({(k == n - 1), 8'(base + k)});
    endtask

    task automatic push_exp(input int s, input int n, input int base);
`ifdef TX_SRC_TAG_EN
        exp_q.push_back({4'hA, 1'b0, 3'(s)});
`endif
        for (int k = 0; k < n; k++) exp_q.push_back(8'(base + k));
    endtask

    task automatic wait_acc(input int s, input int n);
        int c;
        c = 0;
        while (acc_cnt[s] < n && c < 2000) begin
            tick();
            c++;
        end
        chk("acc_reached", acc_cnt[s] >= n, 1);
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            tick();
            c++;
        end
        tick();
        tick();
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NSRC; i++) begin
            src_q[i].delete();
            acc_cnt[i] = 0;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        gap_en    = 1'b0;
        gap_seen  = 1'b0;
        RSTn      = 1'b0;
        SiTCP_RST = 1'b0;
        OPEN_ACK  = 1'b1;
        TX_FULL   = 1'b0;
        repeat (3) tick();
        chk("rst_tx_wr", TX_WR, 0);
        chk("rst_tx_data", TX_DATA, 0);
        chk("rst_grant", GRANT, 0);
        chk("rst_ready", SRC_READY, 0);
        chk("rst_active", ACTIVE, 0);
        chk("rst_drop", DROP_CNT, 0);
        chk("rst_state", DBG_STATE, 0);
        RSTn = 1'b1;
        repeat (2) tick();

        // single source, then ptr must sit at 2
        push_exp(1, 5, 8'h11);
        push_pkt(1, 5, 8'h11);
        drain("t1_drain");
        chk("t1_grant", pop_grant(), 4'b0010);
        push_exp(2, 1, 8'h22);
        push_exp(1, 1, 8'h21);
        push_pkt(1, 1, 8'h21);
        push_pkt(2, 1, 8'h22);
        drain("t1_ptr_drain");
        chk("t1_ptr_first", pop_grant(), 4'b0100);
        chk("t1_ptr_second", pop_grant(), 4'b0010);
        push_exp(3, 1, 8'h33);
        push_pkt(3, 1, 8'h33);
        drain("t1_src3_drain");
        chk("t1_src3_grant", pop_grant(), 4'b1000);

        // round robin from ptr 0
        gap_seen = 1'b0;
        gap_en   = 1'b1;
        push_exp(0, 2, 8'h00);
        push_exp(1, 2, 8'h10);
        push_exp(2, 2, 8'h20);
        push_exp(3, 2, 8'h30);
        push_exp(0, 2, 8'h08);
        push_pkt(0, 2, 8'h00);
        push_pkt(0, 2, 8'h08);
        push_pkt(1, 2, 8'h10);
        push_pkt(2, 2, 8'h20);
        push_pkt(3, 2, 8'h30);
        drain("t2_drain");
        gap_en = 1'b0;
        chk("t2_g0", pop_grant(), 4'b0001);
        chk("t2_g1", pop_grant(), 4'b0010);
        chk("t2_g2", pop_grant(), 4'b0100);
        chk("t2_g3", pop_grant(), 4'b1000);
        chk("t2_g4", pop_grant(), 4'b0001);

        // back-pressure in a 256-byte packet from src1
        clear_sources();
        push_exp(1, 256, 0);
        push_pkt(1, 256, 0);
        wait_acc(1, 100 + $urandom_range(0, 20));
        TX_FULL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_full_wr", TX_WR, 0);
            chk("t3_full_rdy", SRC_READY, 0);
        end
        TX_FULL = 1'b0;
        drain("t3_drain");
        chk("t3_all_bytes", acc_cnt[1], 256);
        chk("t3_grant", pop_grant(), 4'b0010);

        // close mid-packet on src2
        clear_sources();
        push_exp(2, 3, 8'h30);
        push_pkt(2, 10, 8'h30);
        wait_acc(2, 3);
        OPEN_ACK = 1'b0;
        wait_acc(2, 10);
        repeat (3) tick();
        chk("t4_drop", DROP_CNT, 1);
        chk("t4_grant_idle", GRANT, 0);
        chk("t4_active", ACTIVE, 0);
        chk("t4_written", exp_q.size(), 0);
        push_pkt(1, 1, 8'h77);
        repeat (8) tick();
        chk("t4_closed_grant", GRANT, 0);
        chk("t4_closed_ready", SRC_READY, 0);
        push_exp(1, 1, 8'h77);
        OPEN_ACK = 1'b1;
        drain("t4_reopen_drain");
        chk("t4_g_flush", pop_grant(), 4'b0100);
        chk("t4_g_reopen", pop_grant(), 4'b0010);

        // asynchronous reset in mid-packet (ptr is 2 here)
        clear_sources();
        push_exp(2, 3, 8'h40);
        push_pkt(2, 20, 8'h40);
        wait_acc(2, 4);
        RSTn = 1'b0;
        #1;
        chk("t5a_tx_wr", TX_WR, 0);
        chk("t5a_grant", GRANT, 0);
        chk("t5a_ready", SRC_READY, 0);
        chk("t5a_drop", DROP_CNT, 0);
        clear_sources();
        repeat (2) tick();
        RSTn = 1'b1;
        repeat (4) tick();
        chk("t5a_written", exp_q.size(), 0);
        chk("t5a_g_cut", pop_grant(), 4'b0100);
        push_exp(1, 1, 8'h61);
        push_exp(3, 1, 8'h63);
        push_pkt(1, 1, 8'h61);
        push_pkt(3, 1, 8'h63);
        drain("t5a_drain");
        chk("t5a_g_first", pop_grant(), 4'b0010);
        chk("t5a_g_second", pop_grant(), 4'b1000);

        // synchronous SiTCP_RST in mid-packet, from ptr 2
        push_exp(1, 1, 8'h71);
        push_pkt(1, 1, 8'h71);
        drain("t5b_pre_drain");
        chk("t5b_g_pre", pop_grant(), 4'b0010);
        clear_sources();
        push_exp(3, 4, 8'h80);
        push_pkt(3, 20, 8'h80);
        wait_acc(3, 4);
        SiTCP_RST = 1'b1;
        tick();
        chk("t5b_tx_wr", TX_WR, 0);
        chk("t5b_grant", GRANT, 0);
        chk("t5b_ready", SRC_READY, 0);
        chk("t5b_drop", DROP_CNT, 0);
        chk("t5b_active", ACTIVE, 0);
        clear_sources();
        SiTCP_RST = 1'b0;
        repeat (4) tick();
        chk("t5b_written", exp_q.size(), 0);
        chk("t5b_g_cut", pop_grant(), 4'b1000);
        push_exp(1, 1, 8'h91);
        push_exp(2, 1, 8'h92);
        push_pkt(1, 1, 8'h91);
        push_pkt(2, 1, 8'h92);
        drain("t5b_drain");
        chk("t5b_g_first", pop_grant(), 4'b0010);
        chk("t5b_g_second", pop_grant(), 4'b0100);

`ifdef TX_SRC_TAG_EN
        // tag byte held back by TX_FULL
        TX_FULL = 1'b1;
        push_exp(2, 1, 8'h5A);
        push_pkt(2, 1, 8'h5A);
        repeat (6) tick();
        chk("t6_tag_held", exp_q.size(), 2);
        chk("t6_tag_ready", SRC_READY, 0);
        chk("t6_tag_active", ACTIVE, 1);
        TX_FULL = 1'b0;
        drain("t6_drain");
        chk("t6_grant", pop_grant(), 4'b0100);
`endif

        repeat (4) tick();
        chk("final_exp_empty", exp_q.size(), 0);
        chk("final_idle", ACTIVE, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
